// File: rtl/wb_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
// The write triple type is also used by the regfile interface.
package wb_arbiter_pkg;

  localparam int unsigned AW_DEF   = 5;
  localparam int unsigned DW_DEF   = 32;
  localparam int unsigned REG_ZERO = 0;

  typedef struct packed {
    logic              we;
    logic [AW_DEF-1:0] wa;
    logic [DW_DEF-1:0] wd;
  } wr_t;

  // Count width holding 0..depth inclusive, for power-of-two depth.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO for buffered long-unit results.
// Push is ignored when full and pop is ignored when empty.
module wb_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 37
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic [W-1:0]         wdata,
  input  logic                 pop,
  output logic [W-1:0]         rdata,
  output logic                 full,
  output logic                 empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[head_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Storage is not reset; pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[tail_q] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        tail_q <= tail_q + 1'b1;
      end
      if (do_pop) begin
        head_q <= head_q + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Merges pipeline writeback and buffered long-unit results onto one regfile
// write port, and tracks registers with outstanding long ops for decode stalls.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = AW_DEF,
  parameter int unsigned DW    = DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wb_we,
  input  logic [AW-1:0] wb_wa,
  input  logic [DW-1:0] wb_wd,
  input  logic          lu_valid,
  output logic          lu_ready,
  input  logic [AW-1:0] lu_wa,
  input  logic [DW-1:0] lu_wd,
  input  logic          iss_valid,
  input  logic [AW-1:0] iss_wa,
  input  logic [AW-1:0] q_ra1,
  input  logic [AW-1:0] q_ra2,
  input  logic [AW-1:0] q_wa,
  output logic          stall,
  output logic          we3,
  output logic [AW-1:0] wa3,
  output logic [DW-1:0] wd3
);

  localparam int unsigned NREG = 2 ** AW;
  localparam int unsigned CW   = cnt_width(DEPTH);

  logic [AW+DW-1:0] fifo_rdata;
  logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [CW-1:0]    fifo_count;
  logic [AW-1:0]    head_wa;
  logic [DW-1:0]    head_wd;

  logic             sel_vld;
  logic [AW-1:0]    sel_wa;
  logic [DW-1:0]    sel_wd;

  logic [NREG-1:1]  pend_q, pend_d;
  logic [NREG-1:0]  pend_vec;

  // lu_ready depends on state only, never on lu_valid.
  assign lu_ready  = ~reset & (fifo_count != CW'(DEPTH));
  assign fifo_push = lu_valid & lu_ready;

  assign head_wa = fifo_rdata[AW+DW-1:DW];
  assign head_wd = fifo_rdata[DW-1:0];

  wb_fifo #(
    .DEPTH (DEPTH),
    .W     (AW + DW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .wdata ({lu_wa, lu_wd}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Pipeline writeback has priority; the FIFO head drains only on idle slots.
  always_comb begin
    sel_vld  = 1'b0;
    sel_wa   = '0;
    sel_wd   = '0;
    fifo_pop = 1'b0;
    if (!reset) begin
      if (wb_we) begin
        sel_vld = 1'b1;
        sel_wa  = wb_wa;
        sel_wd  = wb_wd;
      end else if (!fifo_empty) begin
        sel_vld  = 1'b1;
        sel_wa   = head_wa;
        sel_wd   = head_wd;
        fifo_pop = 1'b1;
      end
    end
  end

  // A slot addressed to r0 is consumed but never reaches the regfile.
  assign we3 = sel_vld & (sel_wa != AW'(REG_ZERO));
  assign wa3 = sel_wa;
  assign wd3 = sel_wd;

  // Set is applied after clear so an issue to the same register wins.
  always_comb begin
    pend_d = pend_q;
    for (int unsigned r = 1; r < NREG; r++) begin
      if (fifo_pop && head_wa == AW'(r)) begin
        pend_d[r] = 1'b0;
      end
      if (iss_valid && iss_wa == AW'(r)) begin
        pend_d[r] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign pend_vec = {pend_q, 1'b0};
  assign stall    = ~reset & (pend_vec[q_ra1] | pend_vec[q_ra2] | pend_vec[q_wa]);

  always @(posedge clk) begin
    if (!reset) begin
      assert (fifo_full == (fifo_count == CW'(DEPTH)))
        else $error("fifo full flag disagrees with count");
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: directed stimulus pushes expected port
// writes into queues; a negedge monitor pops and compares every port write.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          wb_we;
  logic [AW-1:0] wb_wa;
  logic [DW-1:0] wb_wd;
  logic          lu_valid;
  logic          lu_ready;
  logic [AW-1:0] lu_wa;
  logic [DW-1:0] lu_wd;
  logic          iss_valid;
  logic [AW-1:0] iss_wa;
  logic [AW-1:0] q_ra1, q_ra2, q_wa;
  logic          stall;
  logic          we3;
  logic [AW-1:0] wa3;
  logic [DW-1:0] wd3;

  int  n_tests = 0;
  int  n_fail  = 0;
  wr_t exp_wb[$];
  wr_t exp_lu[$];

  always #5 clk = ~clk;

  wb_arbiter #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .wb_we     (wb_we),
    .wb_wa     (wb_wa),
    .wb_wd     (wb_wd),
    .lu_valid  (lu_valid),
    .lu_ready  (lu_ready),
    .lu_wa     (lu_wa),
    .lu_wd     (lu_wd),
    .iss_valid (iss_valid),
    .iss_wa    (iss_wa),
    .q_ra1     (q_ra1),
    .q_ra2     (q_ra2),
    .q_wa      (q_wa),
    .stall     (stall),
    .we3       (we3),
    .wa3       (wa3),
    .wd3       (wd3)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    end
  endtask

  task automatic idle();
    wb_we     = 1'b0;
    wb_wa     = '0;
    wb_wd     = '0;
    lu_valid  = 1'b0;
    lu_wa     = '0;
    lu_wd     = '0;
    iss_valid = 1'b0;
    iss_wa    = '0;
  endtask

  task automatic wb(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wb_we = 1'b1;
    wb_wa = a;
    wb_wd = d;
    if (!reset && a != '0) exp_wb.push_back('{we: 1'b1, wa: a, wd: d});
  endtask

  // keep=0 when the result is expected never to reach the port (r0 or flushed).
  task automatic lu(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit keep);
    lu_valid = 1'b1;
    lu_wa    = a;
    lu_wd    = d;
    if (keep && a != '0) exp_lu.push_back('{we: 1'b1, wa: a, wd: d});
  endtask

  task automatic iss(input logic [AW-1:0] a);
    iss_valid = 1'b1;
    iss_wa    = a;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every port write is matched against the appropriate queue.
  always @(negedge clk) begin
    wr_t e;
    if (reset) begin
      chk("mon_reset_we3", 32'(we3), 32'd0);
    end else if (wb_we) begin
      if (wb_wa != '0) begin
        if (exp_wb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL mon_wb_extra: got wa3=%0d, expected no pipeline write", wa3);
        end else begin
          e = exp_wb.pop_front();
          chk("mon_wb_we3", 32'(we3), 32'd1);
          chk("mon_wb_wa3", 32'(wa3), 32'(e.wa));
          chk("mon_wb_wd3", wd3, e.wd);
        end
      end else begin
        chk("mon_wb_r0_we3", 32'(we3), 32'd0);
      end
    end else if (we3) begin
      if (exp_lu.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL mon_lu_extra: got wa3=%0d wd3=0x%0h, expected no write", wa3, wd3);
      end else begin
        e = exp_lu.pop_front();
        chk("mon_lu_wa3", 32'(wa3), 32'(e.wa));
        chk("mon_lu_wd3", wd3, e.wd);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected end of run");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    idle();
    q_ra1 = '0;
    q_ra2 = '0;
    q_wa  = '0;

    // Inputs driven during reset must be ignored.
    wb(5'd3, 32'hBAD);
    lu(5'd6, 32'h1, 1'b0);
    iss(5'd6);
    q_ra1 = 5'd6;
    @(negedge clk);
    chk("rst_we3", 32'(we3), 32'd0);
    chk("rst_lu_ready", 32'(lu_ready), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    nxt();
    nxt();
    reset = 1'b0;
    idle();
    @(negedge clk);
    chk("post_rst_stall", 32'(stall), 32'd0);
    chk("post_rst_lu_ready", 32'(lu_ready), 32'd1);
    chk("post_rst_we3", 32'(we3), 32'd0);
    nxt();
    q_ra1 = '0;

    // Pipeline priority: six wb writes while r7, r8 wait in the FIFO.
    for (int i = 0; i < 6; i++) begin
      idle();
      wb(5'(10 + i), 32'h100 + 32'(i));
      if (i == 0) lu(5'd7, 32'h11, 1'b1);
      if (i == 1) lu(5'd8, 32'h22, 1'b1);
      @(negedge clk);
      nxt();
    end
    idle();
    @(negedge clk);
    chk("prio_drain1_we3", 32'(we3), 32'd1);
    chk("prio_drain1_wa3", 32'(wa3), 32'd7);
    chk("prio_drain1_wd3", wd3, 32'h11);
    nxt();
    @(negedge clk);
    chk("prio_drain2_wa3", 32'(wa3), 32'd8);
    chk("prio_drain2_wd3", wd3, 32'h22);
    nxt();
    @(negedge clk);
    chk("prio_idle_we3", 32'(we3), 32'd0);
    nxt();

    // Full boundary: fill with wb busy, a fifth push is refused.
    for (int k = 0; k < 4; k++) begin
      idle();
      wb(5'(16 + k), 32'h200 + 32'(k));
      lu(5'(20 + k), 32'hA0 + 32'(k), 1'b1);
      @(negedge clk);
      chk("full_ready_before_push", 32'(lu_ready), 32'd1);
      nxt();
    end
    idle();
    wb(5'd1, 32'h300);
    lu(5'd24, 32'hFF, 1'b0);
    @(negedge clk);
    chk("full_ready_low", 32'(lu_ready), 32'd0);
    nxt();
    idle();
    @(negedge clk);
    chk("full_pop_ready_still_low", 32'(lu_ready), 32'd0);
    chk("full_pop_wa3", 32'(wa3), 32'd20);
    nxt();
    @(negedge clk);
    chk("full_ready_rises", 32'(lu_ready), 32'd1);
    chk("full_pop2_wa3", 32'(wa3), 32'd21);
    nxt();
    @(negedge clk);
    chk("full_pop3_wa3", 32'(wa3), 32'd22);
    nxt();
    @(negedge clk);
    chk("full_pop4_wa3", 32'(wa3), 32'd23);
    nxt();
    @(negedge clk);
    chk("full_empty_we3", 32'(we3), 32'd0);
    nxt();

    // Scoreboard: issue r9, query through each source, drain clears it.
    idle();
    iss(5'd9);
    q_ra2 = 5'd9;
    @(negedge clk);
    chk("sb_stall_same_cycle", 32'(stall), 32'd0);
    nxt();
    idle();
    @(negedge clk);
    chk("sb_stall_ra2", 32'(stall), 32'd1);
    nxt();
    q_ra2 = '0;
    q_ra1 = 5'd9;
    @(negedge clk);
    chk("sb_stall_ra1", 32'(stall), 32'd1);
    nxt();
    q_ra1 = '0;
    q_ra2 = 5'd9;
    lu(5'd9, 32'hDEAD, 1'b1);
    @(negedge clk);
    chk("sb_stall_push", 32'(stall), 32'd1);
    nxt();
    idle();
    @(negedge clk);
    chk("sb_drain_we3", 32'(we3), 32'd1);
    chk("sb_drain_wa3", 32'(wa3), 32'd9);
    chk("sb_drain_wd3", wd3, 32'hDEAD);
    chk("sb_drain_stall", 32'(stall), 32'd1);
    nxt();
    @(negedge clk);
    chk("sb_stall_cleared", 32'(stall), 32'd0);
    nxt();
    q_ra2 = '0;

    // Set/clear collision on r4: the new issue keeps pend set.
    idle();
    iss(5'd4);
    @(negedge clk);
    nxt();
    idle();
    q_wa = 5'd4;
    lu(5'd4, 32'h44, 1'b1);
    @(negedge clk);
    chk("coll_stall_wa", 32'(stall), 32'd1);
    nxt();
    idle();
    iss(5'd4);
    @(negedge clk);
    chk("coll_pop_wa3", 32'(wa3), 32'd4);
    nxt();
    idle();
    @(negedge clk);
    chk("coll_set_wins", 32'(stall), 32'd1);
    nxt();
    lu(5'd4, 32'h45, 1'b1);
    @(negedge clk);
    nxt();
    idle();
    @(negedge clk);
    chk("coll_second_wd3", wd3, 32'h45);
    nxt();
    @(negedge clk);
    chk("coll_cleared", 32'(stall), 32'd0);
    nxt();
    q_wa = '0;

    // Register zero: both sources to r0 are silent; r3 behind r0 proves the pop.
    idle();
    wb(5'd0, 32'hBAD0);
    lu(5'd0, 32'h55, 1'b1);
    iss(5'd0);
    @(negedge clk);
    chk("r0_wb_we3", 32'(we3), 32'd0);
    chk("r0_stall_a", 32'(stall), 32'd0);
    nxt();
    idle();
    lu(5'd3, 32'h33, 1'b1);
    @(negedge clk);
    chk("r0_pop_we3", 32'(we3), 32'd0);
    chk("r0_stall_b", 32'(stall), 32'd0);
    nxt();
    idle();
    @(negedge clk);
    chk("r0_next_we3", 32'(we3), 32'd1);
    chk("r0_next_wa3", 32'(wa3), 32'd3);
    chk("r0_next_wd3", wd3, 32'h33);
    chk("r0_stall_c", 32'(stall), 32'd0);
    nxt();

    // Reset mid-stream: three buffered results and pend[5] are discarded.
    for (int i = 0; i < 3; i++) begin
      idle();
      wb(5'(25 + i), 32'h400 + 32'(i));
      lu(5'(11 + i), 32'h500 + 32'(i), 1'b0);
      if (i == 0) iss(5'd5);
      q_ra1 = 5'd5;
      @(negedge clk);
      if (i == 2) chk("mid_pend_set", 32'(stall), 32'd1);
      nxt();
    end
    reset = 1'b1;
    idle();
    wb(5'd2, 32'h600);
    @(negedge clk);
    chk("mid_rst_we3", 32'(we3), 32'd0);
    chk("mid_rst_stall", 32'(stall), 32'd0);
    chk("mid_rst_lu_ready", 32'(lu_ready), 32'd0);
    nxt();
    reset = 1'b0;
    idle();
    @(negedge clk);
    chk("mid_after_stall", 32'(stall), 32'd0);
    chk("mid_after_we3", 32'(we3), 32'd0);
    chk("mid_after_lu_ready", 32'(lu_ready), 32'd1);
    nxt();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_flushed_we3", 32'(we3), 32'd0);
      nxt();
    end

    chk("end_exp_wb_empty", 32'(exp_wb.size()), 32'd0);
    chk("end_exp_lu_empty", 32'(exp_lu.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
